// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the 5-stage CPU, with load-use hazard detection.
// Captures the decoded instruction from ID and presents it to EX. When a load
// sitting in EX produces a register the ID instruction reads, a one-cycle
// bubble is inserted and the upstream stages are frozen through id_stall.
// EX back-pressure holds the register; a flush turns the contents into a bubble.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   id_*                decoded instruction fields from ID
//   ex_stall            EX cannot accept a new instruction this cycle
//   flush               kill the instruction resident in ID/EX
//   ex_*                registered copies of the id_* fields for EX
//   id_stall            freeze PC and IF/ID this cycle (combinational)
//   bubble_cnt          saturating count of hazard bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              ex_valid_q,     ex_valid_d;
  logic [31:0]       ex_pc_q,        ex_pc_d;
  logic [4:0]        ex_rs1_q,       ex_rs1_d;
  logic [4:0]        ex_rs2_q,       ex_rs2_d;
  logic [4:0]        ex_rd_q,        ex_rd_d;
  logic [31:0]       ex_rs1_data_q,  ex_rs1_data_d;
  logic [31:0]       ex_rs2_data_q,  ex_rs2_data_d;
  logic [31:0]       ex_imm_q,       ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic [CNT_W-1:0]  bubble_cnt_q,   bubble_cnt_d;
  logic              load_use;

  // A load to x0 never produces a value, so it cannot create a hazard.
  always_comb begin
    load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) & id_valid &
               ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                (id_use_rs2 & (id_rs2 == ex_rd_q)));
    id_stall = load_use | ex_stall;
  end

  // Priority: flush > ex_stall (hold) > load_use (bubble) > normal load.
  // A bubble zeroes every field so forwarding compares against x0 and never
  // matches. Only a bubble inserted for a hazard bumps the counter.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_rs1_data_d  = ex_rs1_data_q;
    ex_rs2_data_d  = ex_rs2_data_q;
    ex_imm_d       = ex_imm_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_mem_write_d = ex_mem_write_q;
    bubble_cnt_d   = bubble_cnt_q;

    if (flush || (!ex_stall && load_use)) begin
      ex_valid_d     = 1'b0;
      ex_pc_d        = '0;
      ex_rs1_d       = '0;
      ex_rs2_d       = '0;
      ex_rd_d        = '0;
      ex_rs1_data_d  = '0;
      ex_rs2_data_d  = '0;
      ex_imm_d       = '0;
      ex_ctrl_d      = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      if (!flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else if (!ex_stall) begin
      // An invalid slot still carries its fields, but must never write state.
      ex_valid_d     = id_valid;
      ex_pc_d        = id_pc;
      ex_rs1_d       = id_rs1;
      ex_rs2_d       = id_rs2;
      ex_rd_d        = id_rd;
      ex_rs1_data_d  = id_rs1_data;
      ex_rs2_data_d  = id_rs2_data;
      ex_imm_d       = id_imm;
      ex_ctrl_d      = id_ctrl;
      ex_reg_write_d = id_reg_write & id_valid;
      ex_mem_read_d  = id_mem_read & id_valid;
      ex_mem_write_d = id_mem_write & id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_ctrl_q      <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. The driver applies one ID instruction per
// cycle on the falling edge, advances a reference model of "what sits in EX"
// and queues the expected EX contents; a monitor pops and compares after each
// rising edge. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       d1;
    logic [31:0]       d2;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
    logic              rw;
    logic              mr;
    logic              mw;
  } slot_t;

  typedef struct packed {
    slot_t            ex;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  slot_t             cur = '0;
  logic              use1 = 1'b0, use2 = 1'b0;
  logic              ex_stall = 1'b0, flush = 1'b0;

  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_stall;
  logic [31:0]       ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  // Reference model: the instruction held in EX and the number of hazard bubbles.
  slot_t m_ex = '0;
  int    m_bub = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.valid), .id_pc(cur.pc), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
    .id_rd(cur.rd), .id_use_rs1(use1), .id_use_rs2(use2),
    .id_rs1_data(cur.d1), .id_rs2_data(cur.d2), .id_imm(cur.imm),
    .id_ctrl(cur.ctrl), .id_reg_write(cur.rw), .id_mem_read(cur.mr),
    .id_mem_write(cur.mw), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .id_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  function automatic slot_t actualSlot();
    return {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
            ex_imm, ex_ctrl, ex_reg_write, ex_mem_read, ex_mem_write};
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act,
                             input logic [191:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: the register updates on every rising edge, so each edge presents
  // one output to be checked against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("ex_slot", 192'(actualSlot()), 192'(e.ex));
      checkOutput("bubble_cnt", 192'(bubble_cnt), 192'(e.cnt));
    end
  end

  // Drive one cycle of ID input, check id_stall, advance the model, queue result.
  task automatic applyStimulus(input slot_t in, input logic u1, input logic u2,
                               input logic fl, input logic st);
    bit hazard;
    exp_t e;
    @(negedge clk);
    cur = in; use1 = u1; use2 = u2; flush = fl; ex_stall = st;
    #1;
    hazard = m_ex.valid && m_ex.mr && m_ex.rd != 5'd0 && in.valid &&
             ((u1 && in.rs1 == m_ex.rd) || (u2 && in.rs2 == m_ex.rd));
    checkOutput("id_stall", 192'(id_stall), 192'(hazard || st));
    if (fl) begin
      m_ex = '0;
    end else if (st) begin
      m_ex = m_ex;
    end else if (hazard) begin
      m_ex = '0;
      if (m_bub < CNT_MAX) m_bub++;
    end else begin
      m_ex = in;
      if (!in.valid) begin
        m_ex.rw = 1'b0; m_ex.mr = 1'b0; m_ex.mw = 1'b0;
      end
    end
    e.ex = m_ex;
    e.cnt = CNT_W'(m_bub);
    sb.push_back(e);
  endtask

  function automatic slot_t mkInstr(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic rw, input logic mr);
    slot_t s;
    s = '0;
    s.valid = 1'b1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.d1 = pc ^ 32'hA5A5_0001; s.d2 = pc ^ 32'h5A5A_0002; s.imm = pc + 32'd4;
    s.ctrl = pc[7:0] ^ 8'h3C; s.rw = rw; s.mr = mr;
    return s;
  endfunction

  function automatic slot_t randInstr();
    slot_t s;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.valid = ($urandom_range(0, 9) != 0);
    return s;
  endfunction

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    slot_t r;
    // Reset is asynchronous: outputs must be zero with no clock edge seen.
    cur = randInstr(); use1 = 1'b1; ex_stall = 1'b1;
    #1;
    checkOutput("reset_slot", 192'(actualSlot()), 192'(0));
    checkOutput("reset_cnt", 192'(bubble_cnt), 192'(0));
    checkOutput("reset_id_stall", 192'(id_stall), 192'(1));
    ex_stall = 1'b0;
    #1;
    checkOutput("reset_id_stall_lo", 192'(id_stall), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through.
    applyStimulus(mkInstr(32'h100, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("pass_pc", 192'(ex_pc), 192'(32'h100));
    checkOutput("pass_rd", 192'(ex_rd), 192'(5));
    checkOutput("pass_rw", 192'(ex_reg_write), 192'(1));

    // Load-use: lw x7 then add x8,x7,x2 -> one bubble, then the add.
    applyStimulus(mkInstr(32'h104, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkInstr(32'h108, 5'd8, 5'd7, 5'd2, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("lu_bubble_valid", 192'(ex_valid), 192'(0));
    checkOutput("lu_bubble_rd", 192'(ex_rd), 192'(0));
    checkOutput("lu_cnt", 192'(bubble_cnt), 192'(1));
    applyStimulus(mkInstr(32'h108, 5'd8, 5'd7, 5'd2, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("lu_add_pc", 192'(ex_pc), 192'(32'h108));
    // Load to x0, and a consumer that does not read rs1: no stall either way.
    applyStimulus(mkInstr(32'h10C, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkInstr(32'h110, 5'd8, 5'd0, 5'd2, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkInstr(32'h114, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkInstr(32'h118, 5'd8, 5'd7, 5'd2, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("nouse_pc", 192'(ex_pc), 192'(32'h118));

    // Back-pressure: three stalled cycles with changing ID, then release.
    for (int i = 0; i < 3; i++)
      applyStimulus(mkInstr(32'h200 + 32'(4 * i), 5'd9, 5'd1, 5'd2, 1'b1, 1'b0),
                    1'b1, 1'b1, 1'b0, 1'b1);
    afterEdge();
    checkOutput("bp_hold_pc", 192'(ex_pc), 192'(32'h118));
    applyStimulus(mkInstr(32'h20C, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("bp_release_pc", 192'(ex_pc), 192'(32'h20C));

    // Flush together with ex_stall and load_use.
    applyStimulus(mkInstr(32'h300, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkInstr(32'h304, 5'd8, 5'd7, 5'd2, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1);
    afterEdge();
    checkOutput("flush_valid", 192'(ex_valid), 192'(0));
    checkOutput("flush_cnt", 192'(bubble_cnt), 192'(1));

    // Saturation: 20 load-use events.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mkInstr(32'h400 + 32'(8 * i), 5'd7, 5'd1, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(mkInstr(32'h404 + 32'(8 * i), 5'd8, 5'd7, 5'd2, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    afterEdge();
    checkOutput("sat_cnt", 192'(bubble_cnt), 192'(CNT_MAX));

    // Reset in the middle of a stall clears everything immediately.
    applyStimulus(mkInstr(32'h500, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    afterEdge();
    ex_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_slot", 192'(actualSlot()), 192'(0));
    checkOutput("midrst_cnt", 192'(bubble_cnt), 192'(0));
    m_ex = '0; m_bub = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = randInstr();
      applyStimulus(r, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end
    afterEdge();
    afterEdge();
    checkOutput("sb_drained", 192'(sb.size()), 192'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
